iomem_initiator: RTL
====================

Name: iomem_initiator

Overview:
- Bus-master end of the picosoc iomem interface. It turns single commands from a local controller into iomem transactions: read, write, or read-modify-write.
- It presents the result on a response port: read data plus an error flag.
- It sits between an internal sequencer (for example a debug bridge or init engine) and the iomem peripheral fabric: GPIO, PWM and similar blocks that pulse iomem_ready for one cycle.

Parameters:
- TIMEOUT, 255: max cycles iomem_valid stays high without iomem_ready before the transaction is aborted; range 1..65535.
- TO_W, 16: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  initiator can accept a command
- cmd_op  in  2  0=READ, 1=WRITE, 2=RMW, 3=reserved
- cmd_addr  in  32  target address
- cmd_wdata  in  32  write data (WRITE) or insert data (RMW)
- cmd_wstrb  in  4  byte enables for WRITE; ignored for READ and RMW
- cmd_mask  in  32  RMW bit mask; 1 = take bit from cmd_wdata
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  data read (READ, RMW); 0 for WRITE
- rsp_err  out  1  timeout or reserved op
- iomem_valid  out  1  bus request
- iomem_ready  in  1  bus completion pulse
- iomem_addr  out  32  bus address
- iomem_wdata  out  32  bus write data
- iomem_wstrb  out  4  bus byte strobes; 0 = read
- iomem_rdata  in  32  bus read data

Behaviour:
- All outputs are registered.
- Reset values:
  - rsp_valid=0, rsp_err=0, iomem_valid=0.
  - cmd_ready=1 (combinational from state == IDLE is also permitted).
  - rsp_rdata=0, iomem_addr=0, iomem_wdata=0, iomem_wstrb=0.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - cmd_ready=1. On cmd_valid the command is latched into internal registers.
  - READ or RMW: next state RD, with iomem_wstrb=0 and iomem_valid=1.
  - WRITE: next state WR, with iomem_wstrb=cmd_wstrb and iomem_wdata=cmd_wdata.
  - Reserved op: next state RESP directly, rsp_err=1, no bus cycle.
  - WRITE with cmd_wstrb=0 is still issued as a bus cycle, so it degenerates to a read; rsp_rdata=0 regardless.
- Bus rule:
  - addr, wdata and wstrb are held stable while iomem_valid=1.
  - On the cycle iomem_ready=1 is sampled, iomem_valid goes 0 on the next edge. valid is never high in the cycle after ready, so a slave using "valid && !ready" cannot see a second request.
  - Minimum gap of one cycle with valid low between consecutive bus cycles.
- RD:
  - On iomem_ready, rdata is captured.
  - READ goes to RESP with rsp_rdata=iomem_rdata.
  - RMW computes new = (iomem_rdata & ~cmd_mask) | (cmd_wdata & cmd_mask), stores iomem_rdata as rsp_rdata, drops valid for one cycle, then enters WR with wstrb=4'hF and wdata=new.
- WR:
  - On iomem_ready, go to RESP.
  - rsp_rdata=0 for WRITE; rsp_rdata keeps the pre-modify read value for RMW.
- Timeout:
  - The counter clears on every rising of iomem_valid and increments each cycle valid=1 and ready=0.
  - When it reaches TIMEOUT: valid drops, rsp_err=1, go to RESP. For RMW the write phase is skipped.
  - A ready arriving in the same cycle the count reaches TIMEOUT counts as success (ready wins).
- RESP:
  - rsp_valid=1, with rsp_rdata and rsp_err held until rsp_ready.
  - On acceptance: rsp_valid=0, rsp_err cleared, back to IDLE.
  - cmd_ready=0 throughout RESP, so there is one outstanding command at most.
- Latency: READ or WRITE against a zero-wait slave is cmd accept at cycle 0, valid at cycles 1..2, rsp_valid at cycle 3.
- A spurious iomem_ready while iomem_valid=0 is ignored.
- Reset mid-transaction:
  - Aborts immediately: valid=0, no response, state IDLE.
  - An RMW interrupted between read and write performs no write.

Decomposition:
- Shared package iomem_pkg holds:
  - op codes OP_READ/OP_WRITE/OP_RMW;
  - state enum constants;
  - WSTRB_READ=4'h0 and WSTRB_ALL=4'hF.
- A single flat module is natural. The timeout counter is small enough to stay inline; no sub-module.

Test Plan:
- READ 0x0300_0000 with a slave returning 0xDEADBEEF after 1 wait cycle:
  - one valid pulse with wstrb=0;
  - rsp_rdata=0xDEADBEEF, rsp_err=0.
- WRITE addr 0x0300_0004, wdata 0x12345678, wstrb 4'b0011:
  - bus shows those values stable during valid; valid low the cycle after ready;
  - rsp_err=0, rsp_rdata=0.
- RMW with slave register 0xFFFF0000, mask 0x000000FF, wdata 0x000000AB:
  - read then write of 0xFFFF00AB with wstrb 4'hF, two distinct valid pulses;
  - rsp_rdata=0xFFFF0000.
- TIMEOUT=8 with slave never ready:
  - valid high exactly 8 cycles, then low;
  - rsp_err=1; for RMW, no write cycle follows.
- Back-pressure: hold rsp_ready=0 for 5 cycles with cmd_valid held:
  - rsp stable, cmd_ready=0, no new bus cycle until accept.
- Reset asserted during RMW write phase:
  - valid=0 next edge, no rsp_valid;
  - a following READ completes normally.

Source files
------------

// File: rtl/iomem_pkg.sv
// Shared definitions for the iomem bus-master block: command op codes,
// initiator FSM states and the byte-strobe constants used on the bus.
package iomem_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_RMW   = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } state_e;

  localparam logic [3:0] WSTRB_READ = 4'h0;
  localparam logic [3:0] WSTRB_ALL  = 4'hF;

  // Bits set in mask come from ins, the rest from old.
  function automatic logic [31:0] rmw_merge(input logic [31:0] old,
                                            input logic [31:0] ins,
                                            input logic [31:0] mask);
    return (old & ~mask) | (ins & mask);
  endfunction

endpackage

// File: rtl/iomem_initiator_if.sv
// picosoc iomem bus bundle.
//   valid  master->slave  request
//   ready  slave->master  one-cycle completion pulse
//   addr   master->slave  address
//   wdata  master->slave  write data
//   wstrb  master->slave  byte strobes, 0 = read
//   rdata  slave->master  read data, sampled with ready
interface iomem_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/iomem_initiator.sv
// Bus-master end of the picosoc iomem interface. Accepts one command at a
// time from a local sequencer and runs it as a READ, WRITE or
// read-modify-write bus transaction, then returns read data and an error
// flag (timeout or reserved op) on the response port.
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op                0=READ 1=WRITE 2=RMW 3=reserved
//   cmd_addr/cmd_wdata    target address, write/insert data
//   cmd_wstrb             byte enables (WRITE only)
//   cmd_mask              RMW mask, 1 = take bit from cmd_wdata
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata/rsp_err     read data (0 for WRITE), error flag
//   iomem                 iomem bus, master side
module iomem_initiator
  import iomem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  input  logic [31:0] cmd_mask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  iomem_if.master     iomem
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e          state;
  op_e             op_q;
  logic [31:0]     wdata_q;
  logic [31:0]     mask_q;
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      op_q        <= OP_READ;
      wdata_q     <= '0;
      mask_q      <= '0;
      to_cnt      <= '0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      iomem.valid <= 1'b0;
      iomem.addr  <= '0;
      iomem.wdata <= '0;
      iomem.wstrb <= WSTRB_READ;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ready  <= 1'b0;
            op_q       <= op_e'(cmd_op);
            wdata_q    <= cmd_wdata;
            mask_q     <= cmd_mask;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            iomem.addr <= cmd_addr;
            to_cnt     <= '0;
            case (op_e'(cmd_op))
              OP_READ, OP_RMW: begin
                iomem.wstrb <= WSTRB_READ;
                iomem.wdata <= '0;
                iomem.valid <= 1'b1;
                state       <= ST_RD;
              end
              OP_WRITE: begin
                iomem.wstrb <= cmd_wstrb;
                iomem.wdata <= cmd_wdata;
                iomem.valid <= 1'b1;
                state       <= ST_WR;
              end
              default: begin
                rsp_err   <= 1'b1;
                rsp_valid <= 1'b1;
                state     <= ST_RESP;
              end
            endcase
          end
        end

        // valid is always high in RD; ready is checked before the timeout
        // so a completion on the final counted cycle still succeeds.
        ST_RD: begin
          if (iomem.ready) begin
            iomem.valid <= 1'b0;
            rsp_rdata   <= iomem.rdata;
            if (op_q == OP_RMW) begin
              iomem.wdata <= rmw_merge(iomem.rdata, wdata_q, mask_q);
              iomem.wstrb <= WSTRB_ALL;
              state       <= ST_WR;
            end else begin
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end
          end else if (to_cnt == TO_LAST) begin
            iomem.valid <= 1'b0;
            rsp_err     <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        // Entering WR with valid low only happens after an RMW read: that
        // cycle is the mandatory idle gap, and a stray ready is ignored.
        ST_WR: begin
          if (!iomem.valid) begin
            iomem.valid <= 1'b1;
            to_cnt      <= '0;
          end else if (iomem.ready) begin
            iomem.valid <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end else if (to_cnt == TO_LAST) begin
            iomem.valid <= 1'b0;
            rsp_err     <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
